// File: rtl/uart_tx.sv
// uart_tx - 8N1 serial transmitter with a one-byte holding register.
//
// Sends 1 start bit (0), 8 data bits LSB first and 1 stop bit (1), each bit
// lasting BAUD_DIV clk cycles. A byte accepted while a frame is on the line
// waits in a holding register and follows the current stop bit with no gap.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   trmt     in   transmit request (pulse or level)
//   tx_data  in   byte to send, sampled when trmt is accepted
//   TX       out  serial line, idle high, driven straight from a flop
//   tx_rdy   out  holding register empty, a new trmt will be accepted
//   tx_done  out  sticky, set when the last queued frame finishes
module uart_tx #(
  parameter int BAUD_DIV = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_rdy,
  output logic       tx_done
);

  typedef enum logic {IDLE = 1'b0, XMIT = 1'b1} state_t;

  localparam logic [12:0] BAUD_LAST = 13'(BAUD_DIV - 1);

  state_t      state_q, state_d;
  logic [9:0]  shift_q, shift_d;
  logic [12:0] baud_cnt_q, baud_cnt_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  hold_data_q, hold_data_d;
  logic        hold_full_q, hold_full_d;
  logic        tx_done_q, tx_done_d;
  logic        accept_s;
  logic        frame_end_s;

  // Next-state, datapath and acceptance logic.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    baud_cnt_d  = baud_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    hold_data_d = hold_data_q;
    hold_full_d = hold_full_q;
    tx_done_d   = tx_done_q;

    accept_s = trmt & ~hold_full_q;
    // The tenth shift is the end of the stop bit; the frame boundary is
    // handled on that same edge so back-to-back frames have no idle gap.
    frame_end_s = (state_q == XMIT) && (baud_cnt_q == BAUD_LAST) && (bit_cnt_q == 4'd9);

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          shift_d    = {1'b1, tx_data, 1'b0};
          baud_cnt_d = 13'd0;
          bit_cnt_d  = 4'd0;
          tx_done_d  = 1'b0;
          state_d    = XMIT;
        end else if (hold_full_q) begin
          shift_d     = {1'b1, hold_data_q, 1'b0};
          hold_full_d = 1'b0;
          baud_cnt_d  = 13'd0;
          bit_cnt_d   = 4'd0;
          state_d     = XMIT;
        end else begin
          shift_d = shift_q;
        end
      end
      XMIT: begin
        if (baud_cnt_q == BAUD_LAST) begin
          baud_cnt_d = 13'd0;
          if (frame_end_s) begin
            bit_cnt_d = 4'd0;
            if (hold_full_q) begin
              shift_d     = {1'b1, hold_data_q, 1'b0};
              hold_full_d = 1'b0;
            end else if (accept_s) begin
              // Request on the closing edge goes straight into the shifter.
              shift_d   = {1'b1, tx_data, 1'b0};
              tx_done_d = 1'b0;
            end else begin
              shift_d   = 10'h3FF;
              tx_done_d = 1'b1;
              state_d   = IDLE;
            end
          end else begin
            shift_d   = {1'b1, shift_q[9:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 13'd1;
        end
        // Mid-frame request is parked in the holding register.
        if (accept_s && !frame_end_s) begin
          hold_data_d = tx_data;
          hold_full_d = 1'b1;
          tx_done_d   = 1'b0;
        end else begin
          hold_data_d = hold_data_d;
        end
      end
      default: begin
        state_d     = IDLE;
        shift_d     = 10'h3FF;
        baud_cnt_d  = 13'd0;
        bit_cnt_d   = 4'd0;
        hold_full_d = 1'b0;
        tx_done_d   = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= 10'h3FF;
      baud_cnt_q  <= 13'd0;
      bit_cnt_q   <= 4'd0;
      hold_data_q <= 8'd0;
      hold_full_q <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      hold_data_q <= hold_data_d;
      hold_full_q <= hold_full_d;
      tx_done_q   <= tx_done_d;
    end
  end

  assign TX      = shift_q[0];
  assign tx_rdy  = ~hold_full_q;
  assign tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       trmt = 1'b0;
  logic [7:0] tx_data = 8'd0;
  logic       tx4, rdy4, done4;
  logic       trmt2 = 1'b0;
  logic [7:0] tx_data2 = 8'd0;
  logic       tx2, rdy2, done2;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb_q[$];

  always #5 clk = ~clk;

  uart_tx #(.BAUD_DIV(4)) dut (
    .clk(clk), .rst(rst), .trmt(trmt), .tx_data(tx_data),
    .TX(tx4), .tx_rdy(rdy4), .tx_done(done4)
  );

  uart_tx dut_def (
    .clk(clk), .rst(rst), .trmt(trmt2), .tx_data(tx_data2),
    .TX(tx2), .tx_rdy(rdy2), .tx_done(done2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one trmt pulse; afterwards scramble tx_data to prove it is not re-sampled.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    trmt = 1'b1;
    tx_data = b;
    @(negedge clk);
    trmt = 1'b0;
    tx_data = ~b;
  endtask

  // Frame monitor for the BAUD_DIV=4 instance: captures 40 samples per frame.
  initial begin
    logic [39:0] s;
    logic [9:0]  fr;
    logic        abort;
    logic        consistent;
    logic [7:0]  exp_b;
    forever begin
      @(negedge clk);
      if (!rst && tx4 === 1'b0) begin
        s = '0;
        abort = 1'b0;
        for (int i = 1; i < 40; i++) begin
          @(negedge clk);
          if (rst) begin
            abort = 1'b1;
            break;
          end
          s[i] = tx4;
        end
        if (!abort) begin
          consistent = 1'b1;
          for (int i = 0; i < 40; i++)
            if (s[i] !== s[(i / 4) * 4]) consistent = 1'b0;
          for (int b = 0; b < 10; b++) fr[b] = s[b * 4];
          chk("bit_width", 32'(consistent), 32'd1);
          chk("start_stop", {30'd0, fr[9], fr[0]}, 32'h2);
          chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
          if (sb_q.size() != 0) begin
            exp_b = sb_q.pop_front();
            chk("frame_data", 32'(fr[8:1]), 32'(exp_b));
          end
        end
      end
    end
  end

  initial begin
    logic stay;
    int   cnt;

    // Reset and idle line.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_tx", 32'(tx4), 32'd1);
    chk("rst_rdy", 32'(rdy4), 32'd1);
    chk("rst_done", 32'(done4), 32'd0);
    stay = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (tx4 !== 1'b1) stay = 1'b0;
    end
    chk("idle_tx_high", 32'(stay), 32'd1);

    // Single byte 0xA5: line falls right after acceptance, done 40 cycles later.
    sb_q.push_back(8'hA5);
    send(8'hA5);
    chk("a5_start_low", 32'(tx4), 32'd0);
    repeat (39) @(negedge clk);
    chk("a5_done_early", 32'(done4), 32'd0);
    @(negedge clk);
    chk("a5_done", 32'(done4), 32'd1);
    chk("a5_tx_idle", 32'(tx4), 32'd1);
    repeat (10) @(negedge clk);
    chk("a5_done_held", 32'(done4), 32'd1);

    // Back-to-back 0x00 then 0xFF, plus an ignored 0x3C while the hold is full.
    sb_q.push_back(8'h00);
    send(8'h00);
    chk("b2b_done_cleared", 32'(done4), 32'd0);
    repeat (9) @(negedge clk);
    sb_q.push_back(8'hFF);
    send(8'hFF);
    chk("b2b_rdy_low", 32'(rdy4), 32'd0);
    send(8'h3C);
    chk("ovf_rdy_low", 32'(rdy4), 32'd0);
    repeat (26) @(negedge clk);
    chk("b2b_rdy_before_end", 32'(rdy4), 32'd0);
    @(negedge clk);
    chk("b2b_rdy_after_end", 32'(rdy4), 32'd1);
    chk("b2b_zero_gap", 32'(tx4), 32'd0);
    chk("b2b_no_done_mid", 32'(done4), 32'd0);
    repeat (39) @(negedge clk);
    chk("b2b_done_early", 32'(done4), 32'd0);
    @(negedge clk);
    chk("b2b_done", 32'(done4), 32'd1);
    repeat (50) @(negedge clk);
    chk("ovf_dropped", 32'(sb_q.size()), 32'd0);

    // Request on the exact edge the final frame ends: direct reload, no done.
    sb_q.push_back(8'h12);
    send(8'h12);
    repeat (38) @(negedge clk);
    sb_q.push_back(8'h34);
    send(8'h34);
    chk("edge_req_no_done", 32'(done4), 32'd0);
    chk("edge_req_start", 32'(tx4), 32'd0);
    chk("edge_req_rdy", 32'(rdy4), 32'd1);
    repeat (40) @(negedge clk);
    chk("edge_req_done", 32'(done4), 32'd1);
    repeat (10) @(negedge clk);

    // Mid-frame reset during bit 4 of 0x55 with 0xAA queued.
    send(8'h55);
    repeat (9) @(negedge clk);
    send(8'hAA);
    chk("mrst_hold_full", 32'(rdy4), 32'd0);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_tx", 32'(tx4), 32'd1);
    chk("mrst_rdy", 32'(rdy4), 32'd1);
    chk("mrst_done", 32'(done4), 32'd0);
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    stay = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (tx4 !== 1'b1) stay = 1'b0;
    end
    chk("mrst_no_frames", 32'(stay), 32'd1);
    chk("mrst_done_after", 32'(done4), 32'd0);

    // Default BAUD_DIV instance: start bit width and whole-frame length for 0x01.
    @(negedge clk);
    trmt2 = 1'b1;
    tx_data2 = 8'h01;
    @(negedge clk);
    trmt2 = 1'b0;
    tx_data2 = 8'hFE;
    cnt = 0;
    while (tx2 === 1'b0 && cnt < 6000) begin
      cnt++;
      @(negedge clk);
    end
    chk("def_start_width", 32'(cnt), 32'd5208);
    while (done2 !== 1'b1 && cnt < 60000) begin
      cnt++;
      @(negedge clk);
    end
    chk("def_frame_len", 32'(cnt), 32'd52080);
    chk("def_tx_idle", 32'(tx2), 32'd1);

    repeat (5) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter BAUD_DIV, default 5208, clk cycles per serial bit (9600 baud at 50 MHz); legal range 2..8191 (13-bit counter).
REQ-002 clk  input  1  system clock; all logic on rising edge; single clock domain.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 trmt  input  1  transmit request; a one-cycle pulse or a level, sampled every clk edge.
REQ-005 tx_data  input  8  byte to send; sampled only in the cycle trmt is accepted.
REQ-006 TX  output  1  serial line; idle high; registered, glitch-free.
REQ-007 tx_rdy  output  1  high when the holding register is empty and a new trmt will be accepted.
REQ-008 tx_done  output  1  sticky; high after the last queued frame's stop bit completes.

Function
REQ-009 Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); no parity; each bit lasts exactly BAUD_DIV cycles.
REQ-010 Datapath: 10-bit shift register {1, data[7:0], 0} with TX = shift_reg[0] (registered); 13-bit baud_cnt; 4-bit bit_cnt; 8-bit hold_data plus hold_full flag.
REQ-011 FSM states: IDLE and XMIT; reset state IDLE.
REQ-012 IDLE -> XMIT on an accepted trmt or when hold_full=1; the shift register loads on that edge, so TX falls on the next cycle.
REQ-013 In XMIT, baud_cnt counts up from 0; at BAUD_DIV-1 it wraps to 0, the shift register shifts right filling with 1, and bit_cnt increments.
REQ-014 When bit_cnt reaches 10 (stop bit complete), behaviour depends on hold_full:
  - hold_full=1: load hold_data into the shifter, clear hold_full, stay in XMIT; the frames are back-to-back with no idle gap.
  - hold_full=0: go to IDLE, set tx_done, and keep TX=1.
REQ-015 Acceptance rule: trmt is accepted iff tx_rdy=1 (hold_full=0); a trmt while hold_full=1 is ignored with no side effect.
REQ-016 An accepted trmt in IDLE loads the byte directly into the shifter; hold_full stays 0.
REQ-017 An accepted trmt in XMIT captures tx_data into hold_data and sets hold_full.
REQ-018 A trmt in the same cycle the final frame ends (hold empty) is treated as a direct shifter load; the frame starts back-to-back and tx_done does not assert.
REQ-019 tx_done clears on the edge any trmt is accepted; otherwise it holds.
REQ-020 tx_data changes after acceptance do not affect the frame in progress or the queued byte.
REQ-021 tx_rdy = !hold_full, driven combinationally from the flop.

Reset
REQ-022 With rst=1 at a clk edge, the next state is: IDLE, TX=1, tx_rdy=1, tx_done=0, baud_cnt=0, bit_cnt=0, hold_full=0, shift register all 1s.
REQ-023 rst mid-frame aborts the frame immediately (TX=1 next cycle) and discards any queued byte; rst has priority over trmt.

Verification (BAUD_DIV=4 unless noted)
REQ-024 Reset: rst high 2 cycles then low -> TX=1, tx_rdy=1, tx_done=0, and TX stays 1 for 100 cycles with no trmt.
REQ-025 Single byte: trmt pulse with tx_data=0xA5 at edge k -> TX from edge k+1 is bits 0,1,0,1,0,0,1,0,1,1, each 4 cycles wide; tx_done=1 from edge k+41 and held.
REQ-026 Back-to-back: send 0x00, then trmt 0xFF 10 cycles later -> tx_rdy=0 until the first stop bit ends, the second frame's start bit follows the first stop bit with zero gap, and tx_done rises only after the second frame.
REQ-027 Overflow: while hold_full=1, trmt with 0x3C -> ignored; only the first two bytes appear on TX.
REQ-028 Mid-frame reset: rst asserted at bit 4 of 0x55 with a byte queued -> TX=1, tx_rdy=1, tx_done=0 the next cycle, and no further frames.
REQ-029 Default timing: BAUD_DIV=5208, byte 0x01 -> start-bit low for exactly 5208 cycles, and the whole frame takes 52080 cycles.
